// File: rtl/bus_arbiter.sv
// Fixed-priority (m2 > m0 > m1) single-slave bus arbiter with transaction-locked grant.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_we_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_we_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  input  logic              m2_req_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  input  logic              m2_we_i,
  output logic              m2_ack_o,
  output logic [DATA_W-1:0] m2_rdata_o,

  output logic              slv_req_o,
  output logic [ADDR_W-1:0] slv_addr_o,
  output logic [DATA_W-1:0] slv_wdata_o,
  output logic              slv_we_o,
  input  logic              slv_ack_i,
  input  logic [DATA_W-1:0] slv_rdata_i,

  output logic              hold_flag_o,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy;
  logic        to_fire;
  logic        done;
  logic        rd_done;

  logic              sel_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic [1:0]        winner;

  assign busy = (state_q == BUSY);

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_req   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (busy) begin
      case (grant_q)
        2'd0: begin
          sel_req   = m0_req_i;
          sel_addr  = m0_addr_i;
          sel_wdata = m0_wdata_i;
          sel_we    = m0_we_i;
        end
        2'd1: begin
          sel_req   = m1_req_i;
          sel_addr  = m1_addr_i;
          sel_wdata = m1_wdata_i;
          sel_we    = m1_we_i;
        end
        2'd2: begin
          sel_req   = m2_req_i;
          sel_addr  = m2_addr_i;
          sel_wdata = m2_wdata_i;
          sel_we    = m2_we_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (m2_req_i)      winner = 2'd2;
    else if (m0_req_i) winner = 2'd0;
    else               winner = 2'd1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt_q, to_cnt_d;

  assign to_fire = busy && !slv_ack_i && (to_cnt_q == TO_LAST);

  // Held at zero in IDLE so every BUSY stretch starts counting from zero.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!busy)           to_cnt_d = 8'd0;
    else if (!slv_ack_i) to_cnt_d = to_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= 8'd0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i || m2_req_i) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (slv_ack_i || to_fire) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign done    = busy && (slv_ack_i || to_fire);
  assign rd_done = busy && slv_ack_i && !sel_we;

  assign slv_req_o   = sel_req && !to_fire;
  assign slv_addr_o  = sel_addr;
  assign slv_wdata_o = sel_wdata;
  assign slv_we_o    = sel_we;

  assign m0_ack_o = done && (grant_q == 2'd0);
  assign m1_ack_o = done && (grant_q == 2'd1);
  assign m2_ack_o = done && (grant_q == 2'd2);

  assign m0_rdata_o = (rd_done && grant_q == 2'd0) ? slv_rdata_i : '0;
  assign m1_rdata_o = (rd_done && grant_q == 2'd1) ? slv_rdata_i : '0;
  assign m2_rdata_o = (rd_done && grant_q == 2'd2) ? slv_rdata_i : '0;

  // Ifetch stalls whenever it asks for the bus and does not currently own it.
  assign hold_flag_o = m1_req_i && !(busy && grant_q == 2'd1);
  assign grant_o     = grant_q;
  assign timeout_o   = to_fire;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a behavioural model.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];

  logic          m0_ack, m1_ack, m2_ack;
  logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
  logic          slv_req_o, slv_we_o, hold_flag_o, timeout_o;
  logic [AW-1:0] slv_addr_o;
  logic [DW-1:0] slv_wdata_o;
  logic [1:0]    grant_o;

  logic          slv_ack;
  logic [DW-1:0] slv_rdata = '0;
  int            slv_wait = 0;
  int            slv_delay = 0;
  logic          slv_never = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  wire [2:0]    ack_vec = {m2_ack, m1_ack, m0_ack};
  wire [DW-1:0] rdata_arr [3];
  assign rdata_arr[0] = m0_rdata;
  assign rdata_arr[1] = m1_rdata;
  assign rdata_arr[2] = m2_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]), .m0_we_i(we[0]),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]), .m1_we_i(we[1]),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .m2_req_i(req[2]), .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]), .m2_we_i(we[2]),
    .m2_ack_o(m2_ack), .m2_rdata_o(m2_rdata),
    .slv_req_o(slv_req_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
    .slv_we_o(slv_we_o), .slv_ack_i(slv_ack), .slv_rdata_i(slv_rdata),
    .hold_flag_o(hold_flag_o), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // Slave: acks combinationally once it has seen slv_delay waiting cycles.
  assign slv_ack = slv_req_o && !slv_never && (slv_wait >= slv_delay);
  always @(posedge clk) slv_wait <= (slv_req_o && !slv_ack) ? slv_wait + 1 : 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Behavioural model: who owns the bus, and for how many cycles it has waited.
  int            m_owner = 3;
  int            m_busy = 0;
  logic          m_to;
  logic [1:0]    e_grant;
  logic          e_sreq, e_swe, e_hold;
  logic [AW-1:0] e_saddr;
  logic [DW-1:0] e_swdata;
  logic [2:0]    e_ack;
  logic [DW-1:0] e_rd [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 3;
      m_busy  = 0;
    end
    e_grant  = 2'(m_owner);
    e_sreq   = 1'b0;
    e_swe    = 1'b0;
    e_saddr  = '0;
    e_swdata = '0;
    e_ack    = '0;
    for (int i = 0; i < 3; i++) e_rd[i] = '0;
    m_to = 1'b0;
    if (m_owner != 3) begin
`ifdef ARB_TIMEOUT_EN
      m_to = !slv_ack && (m_busy == TO - 1);
`endif
      e_sreq   = req[m_owner] && !m_to;
      e_swe    = we[m_owner];
      e_saddr  = addr[m_owner];
      e_swdata = wdata[m_owner];
      e_ack[m_owner] = slv_ack || m_to;
      if (slv_ack && !we[m_owner]) e_rd[m_owner] = slv_rdata;
    end
    e_hold = req[1] && (m_owner != 1);

    check("grant",     64'(grant_o),     64'(e_grant));
    check("slv_req",   64'(slv_req_o),   64'(e_sreq));
    check("slv_we",    64'(slv_we_o),    64'(e_swe));
    check("slv_addr",  64'(slv_addr_o),  64'(e_saddr));
    check("slv_wdata", 64'(slv_wdata_o), 64'(e_swdata));
    check("ack_vec",   64'(ack_vec),     64'(e_ack));
    check("hold",      64'(hold_flag_o), 64'(e_hold));
    check("timeout",   64'(timeout_o),   64'(m_to));
    for (int i = 0; i < 3; i++) check($sformatf("m%0d_rdata", i), 64'(rdata_arr[i]), 64'(e_rd[i]));

    if (rst_n) begin
      if (m_owner == 3) begin
        if (req[2])      m_owner = 2;
        else if (req[0]) m_owner = 0;
        else if (req[1]) m_owner = 1;
        m_busy = 0;
      end else if (slv_ack || m_to) begin
        m_owner = 3;
      end else begin
        m_busy++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] seen;
    logic [1:0] exp_g;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end

    // Reset values
    smp();
    check("rst_grant", 64'(grant_o), 64'(2'd3));
    check("rst_ack",   64'(ack_vec), 64'(3'b000));
    check("rst_sreq",  64'(slv_req_o), 64'(1'b0));
    go();
    rst_n = 1'b1;

    // m1 read, combinational slave
    slv_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      go();
      if (c == 0) begin req[1] = 1'b1; addr[1] = 32'h10; we[1] = 1'b0; end
      if (c == 2) req[1] = 1'b0;
      smp();
      exp_g = (c == 1) ? 2'd1 : 2'd3;
      check("t1_grant", 64'(grant_o), 64'(exp_g));
      check("t1_hold",  64'(hold_flag_o), 64'(c == 0));
      check("t1_ack",   64'(m1_ack), 64'(c == 1));
      if (c == 1) check("t1_rdata", 64'(m1_rdata), 64'(32'h1234_5678));
    end

    // m0 write beats m1 read
    for (int c = 0; c < 5; c++) begin
      go();
      if (c == 0) begin
        req[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'ha5a5_0001; we[0] = 1'b1;
        req[1] = 1'b1; addr[1] = 32'h10;  we[1] = 1'b0;
      end
      if (c == 2) req[0] = 1'b0;
      if (c == 4) req[1] = 1'b0;
      smp();
      exp_g = (c == 1) ? 2'd0 : (c == 3) ? 2'd1 : 2'd3;
      check("t2_grant", 64'(grant_o), 64'(exp_g));
      check("t2_hold",  64'(hold_flag_o), 64'(c <= 2));
      check("t2_ack",   64'(ack_vec), (c == 1) ? 64'(3'b001) : (c == 3) ? 64'(3'b010) : 64'(3'b000));
      if (c == 1) check("t2_we", 64'(slv_we_o), 64'(1'b1));
      if (c == 3) check("t2_rdata", 64'(m1_rdata), 64'(32'h1234_5678));
    end

    // Slow slave, m2 arrives mid-transaction: no preemption
    for (int c = 0; c < 10; c++) begin
      go();
      if (c == 0) begin req[1] = 1'b1; addr[1] = 32'h20; we[1] = 1'b0; slv_delay = 5; end
      if (c == 3) begin req[2] = 1'b1; addr[2] = 32'h30; we[2] = 1'b0; end
      if (c == 7) begin req[1] = 1'b0; slv_delay = 0; end
      if (c == 9) req[2] = 1'b0;
      smp();
      exp_g = (c == 0 || c == 7 || c == 9) ? 2'd3 : (c == 8) ? 2'd2 : 2'd1;
      check("t3_grant", 64'(grant_o), 64'(exp_g));
      check("t3_m1ack", 64'(m1_ack), 64'(c == 6));
      check("t3_m2ack", 64'(m2_ack), 64'(c == 8));
    end

    // Async reset during BUSY with ack pending
    go();
    req[1] = 1'b1; addr[1] = 32'h44; we[1] = 1'b0; slv_delay = 100;
    go();
    smp();
    check("t4_grant_busy", 64'(grant_o), 64'(2'd1));
    go();
    #2 rst_n = 1'b0;
    #1;
    check("t4_grant_rst", 64'(grant_o), 64'(2'd3));
    check("t4_ack_rst",   64'(ack_vec), 64'(3'b000));
    check("t4_sreq_rst",  64'(slv_req_o), 64'(1'b0));
    go();
    rst_n = 1'b1; slv_delay = 0;
    smp();
    check("t4_idle", 64'(grant_o), 64'(2'd3));
    go();
    smp();
    check("t4_regrant", 64'(grant_o), 64'(2'd1));
    check("t4_ack",     64'(m1_ack), 64'(1'b1));
    go();
    req[1] = 1'b0;
    smp();

    // Slave never acks an m0 read
    go();
    req[0] = 1'b1; addr[0] = 32'h40; we[0] = 1'b0; slv_never = 1'b1; slv_rdata = 32'hdead_beef;
    smp();
    check("t5_idle", 64'(grant_o), 64'(2'd3));
    for (int b = 1; b <= 6; b++) begin
      go();
      smp();
`ifdef ARB_TIMEOUT_EN
      if (b == TO) begin
        check("t5_to_ack",   64'(m0_ack), 64'(1'b1));
        check("t5_to_pulse", 64'(timeout_o), 64'(1'b1));
        check("t5_to_rdata", 64'(m0_rdata), 64'(0));
        check("t5_to_sreq",  64'(slv_req_o), 64'(1'b0));
        break;
      end
`endif
      check("t5_grant", 64'(grant_o), 64'(2'd0));
      check("t5_noack", 64'(m0_ack), 64'(1'b0));
      check("t5_noto",  64'(timeout_o), 64'(1'b0));
    end
`ifndef ARB_TIMEOUT_EN
    go();
    slv_never = 1'b0;
    smp();
    check("t5_late_ack", 64'(ack_vec), 64'(3'b001));
`endif
    go();
    req[0] = 1'b0; slv_never = 1'b0;
    smp();
    check("t5_after", 64'(grant_o), 64'(2'd3));

    // m2 back-to-back starves m1
    for (int k = 0; k < 8; k++) begin
      go();
      if (k == 0) begin req[2] = 1'b1; addr[2] = 32'h50; we[2] = 1'b1; req[1] = 1'b1; end
      smp();
      check("t6_grant", 64'(grant_o), (k % 2 == 1) ? 64'(2'd2) : 64'(2'd3));
      check("t6_ack",   64'(m2_ack), 64'(k % 2 == 1));
      check("t6_hold",  64'(hold_flag_o), 64'(1'b1));
    end
    go();
    req[2] = 1'b0;
    smp();
    go();
    smp();
    check("t6_m1_grant", 64'(grant_o), 64'(2'd1));
    go();
    req[1] = 1'b0;
    smp();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      smp();
      seen = ack_vec;
      go();
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || seen[i]) begin
          req[i]   = ($urandom_range(0, 2) == 0);
          addr[i]  = $urandom;
          wdata[i] = $urandom;
          we[i]    = 1'($urandom_range(0, 1));
        end
      end
      slv_rdata = $urandom;
      if (slv_wait == 0) slv_delay = $urandom_range(0, 5);
    end
    smp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
